// File: rtl/lfsr_fib168pi.sv
// lfsr_fib168pi: serial pseudo-random bit source, 28-bit Fibonacci LFSR (x^28 + x^25 + 1) with parallel seed load.
// Latency: r is the register MSB, so the seed MSB appears right after the reset edge; one step per clock.
// Backpressure: none; free-running source that advances on every clock edge without reset.
//
// Ports:
//   clk    - single clock, all state changes on the rising edge
//   reset  - synchronous, active-high; loads the seed (priority over shifting)
//   seed   - WIDTH-bit parallel seed, sampled only on an edge with reset=1
//   r      - serial output bit, taken straight from the register MSB
//
// Optional build macro: LFSR_LOCKUP_GUARD_EN
//   When defined, an all-zero seed loads 1 instead. An all-zero state seen
//   with reset=0 (e.g. after an upset) is also replaced by 1 on the next edge.
//   Non-zero seeds behave identically in both builds.

module lfsr_fib168pi #(
    parameter int WIDTH = 28,
    parameter int TAP   = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] seed,
    output logic             r
);

    // State register; no power-on value, it is defined only once reset is seen.
    logic [WIDTH-1:0] r_q;

    logic             w_fb;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] w_next;

    // Feedback from the two taps; the first tap is always the MSB.
    assign w_fb    = r_q[WIDTH-1] ^ r_q[TAP-1];
    assign w_shift = {r_q[WIDTH-2:0], w_fb};

`ifdef LFSR_LOCKUP_GUARD_EN
    localparam logic [WIDTH-1:0] ONE_STATE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Zero is the lock-up state of this polynomial, so it is never loaded
    // and never kept: both paths are redirected to state 1.
    assign w_load = (seed == '0) ? ONE_STATE : seed;
    assign w_next = (r_q  == '0) ? ONE_STATE : w_shift;
`else
    assign w_load = seed;
    assign w_next = w_shift;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= w_load;
        end else begin
            r_q <= w_next;
        end
    end

    // Output comes directly from the register; no logic after the flop.
    assign r = r_q[WIDTH-1];

endmodule

// File: tb/tb_lfsr_fib168pi.sv
// tb_lfsr_fib168pi: directed bench for the 28-bit Fibonacci LFSR bit source.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: n/a; the bench drives reset/seed and observes r every clock.

module tb_lfsr_fib168pi;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [27:0] seed  = '0;
    logic        r;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: window of the next 28 output bits. Output stream obeys
    // o[t+28] = o[t] ^ o[t+3] for x^28 + x^25 + 1 with a left-shifting register.
    bit win [28];

    lfsr_fib168pi #(.WIDTH(28), .TAP(25)) dut (
        .clk   (clk),
        .reset (reset),
        .seed  (seed),
        .r     (r)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_load(input logic [27:0] s);
        for (int i = 0; i < 28; i++) win[i] = s[27-i];
    endtask

    task automatic model_step();
        bit nb;
        nb = win[0] ^ win[3];
        for (int i = 0; i < 27; i++) win[i] = win[i+1];
        win[27] = nb;
    endtask

    task automatic do_reset(input logic [27:0] s);
        seed  = s;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    logic [7:0]  t1_exp;
    logic [3:0]  t4_exp;
    logic [27:0] t6_seeds [5];

    initial begin
        // Directed vector: seed D8FCED9, bits 26..19 = 1,0,1,1,0,0,0,1
        do_reset(28'hD8FCED9);
        check_eq("t1_reset_r", {31'd0, r}, 32'd1);
        t1_exp = 8'b1011_0001;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq($sformatf("t1_bit%0d", 26 - i), {31'd0, r}, {31'd0, t1_exp[7-i]});
        end

        // Long stream against the recurrence model
        do_reset(28'hD8FCED9);
        model_load(28'hD8FCED9);
        check_eq("t2_r0", {31'd0, r}, {31'd0, win[0]});
        for (int i = 1; i <= 1000; i++) begin
            tick();
            model_step();
            check_eq($sformatf("t2_r%0d", i), {31'd0, r}, {31'd0, win[0]});
        end

        // Mid-run reset at clock 500 with seed AAAAAAA
        do_reset(28'h1234567);
        for (int i = 1; i < 500; i++) tick();
        do_reset(28'hAAAAAAA);
        check_eq("t4_reset_r", {31'd0, r}, 32'd1);
        t4_exp = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("t4_edge%0d", i + 1), {31'd0, r}, {31'd0, t4_exp[3-i]});
        end
        model_load(28'hAAAAAAA);
        for (int i = 0; i < 4; i++) model_step();
        for (int i = 0; i < 60; i++) begin
            tick();
            model_step();
            check_eq($sformatf("t4_cont%0d", i), {31'd0, r}, {31'd0, win[0]});
        end

        // All-zero seed
        do_reset(28'h0);
        check_eq("t5_reset_r", {31'd0, r}, 32'd0);
`ifdef LFSR_LOCKUP_GUARD_EN
        // State 1 moves up one bit per edge; MSB reached on the 27th shift.
        for (int i = 1; i <= 27; i++) begin
            tick();
            check_eq($sformatf("t5g_shift%0d", i), {31'd0, r}, (i == 27) ? 32'd1 : 32'd0);
        end
`else
        for (int i = 1; i <= 100; i++) begin
            tick();
            check_eq($sformatf("t5_lock%0d", i), {31'd0, r}, 32'd0);
        end
`endif

        // Reset held 5 edges while seed toggles; last seed wins
        t6_seeds[0] = 28'h8000001;
        t6_seeds[1] = 28'h7FFFFFE;
        t6_seeds[2] = 28'hC3C3C3C;
        t6_seeds[3] = 28'h1111111;
        t6_seeds[4] = 28'h5A5A5A5;
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            seed = t6_seeds[k];
            tick();
            check_eq($sformatf("t6_hold%0d", k), {31'd0, r}, {31'd0, t6_seeds[k][27]});
        end
        reset = 1'b0;
        model_load(28'h5A5A5A5);
        for (int i = 0; i < 40; i++) begin
            // Seed changes with reset low must not disturb the stream.
            seed = 28'($urandom);
            tick();
            model_step();
            check_eq($sformatf("t6_run%0d", i), {31'd0, r}, {31'd0, win[0]});
        end

        // Reset pulse that spans no rising edge has no effect
        seed  = 28'hFFFFFFF;
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            model_step();
            check_eq($sformatf("t6_glitch%0d", i), {31'd0, r}, {31'd0, win[0]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
